// File: rtl/idecode.sv
// ---------------------------------------------------------------------------
// idecode -- instruction decode stage of a five-stage pipeline.
//
// Holds the 32x32 register file, decodes the opcode into the control bundles
// carried down the pipe, detects load-use hazards and produces the ID/EX
// pipeline register.
//
// Ports
//   clk              single clock, all state updates on the rising edge
//   rst_n            asynchronous active-low reset; clears ID/EX and registers
//   IF_ID_instr      instruction from the IF/ID register
//   IF_ID_npc        PC+1 from the IF/ID register
//   MEM_WB_RegWrite  writeback enable
//   MEM_WB_writereg  writeback destination register
//   WB_writedata     writeback data
//   EX_MEM_PCSrc     taken branch; squashes the instruction being decoded
//   ID_EX_wb         {RegWrite, MemtoReg}
//   ID_EX_m          {Branch, MemRead, MemWrite}
//   ID_EX_ex         {RegDst, ALUOp[1:0], ALUSrc}
//   ID_EX_npc        registered PC+1
//   ID_EX_readdat1   registered rs value
//   ID_EX_readdat2   registered rt value
//   ID_EX_sign_ext   registered sign-extended immediate
//   ID_EX_instr_2016 registered rt field
//   ID_EX_instr_1511 registered rd field
//   ID_stall         combinational load-use hazard flag
// ---------------------------------------------------------------------------
module idecode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IF_ID_instr,
  input  logic [31:0] IF_ID_npc,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_writereg,
  input  logic [31:0] WB_writedata,
  input  logic        EX_MEM_PCSrc,
  output logic [1:0]  ID_EX_wb,
  output logic [2:0]  ID_EX_m,
  output logic [3:0]  ID_EX_ex,
  output logic [31:0] ID_EX_npc,
  output logic [31:0] ID_EX_readdat1,
  output logic [31:0] ID_EX_readdat2,
  output logic [31:0] ID_EX_sign_ext,
  output logic [4:0]  ID_EX_instr_2016,
  output logic [4:0]  ID_EX_instr_1511,
  output logic        ID_stall
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [31:0] regs [32];

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] sign_ext;
  logic [1:0]  wb_dec;
  logic [2:0]  m_dec;
  logic [3:0]  ex_dec;
  logic        wb_write;
  logic        bubble;

  assign opcode   = IF_ID_instr[31:26];
  assign rs       = IF_ID_instr[25:21];
  assign rt       = IF_ID_instr[20:16];
  assign sign_ext = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};

  // Writes to register 0 are dropped here, so it stays zero after reset.
  assign wb_write = MEM_WB_RegWrite && (MEM_WB_writereg != 5'd0);

  // Register file storage. Writeback is independent of stalls and flushes:
  // the instruction in WB has already committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      regs[MEM_WB_writereg] <= WB_writedata;
    end
  end

  // Read ports. A write landing this cycle is forwarded so the decoding
  // instruction sees the new value without waiting for the edge.
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (wb_write && (MEM_WB_writereg == rs)) begin
      rs_val = WB_writedata;
    end
    if (wb_write && (MEM_WB_writereg == rt)) begin
      rt_val = WB_writedata;
    end
    if (rs == 5'd0) begin
      rs_val = '0;
    end
    if (rt == 5'd0) begin
      rt_val = '0;
    end
  end

  // Main control decode. Unknown opcodes decode to an all-zero bubble so
  // they can never write state further down the pipe.
  always_comb begin
    wb_dec = 2'b00;
    m_dec  = 3'b000;
    ex_dec = 4'b0000;
    case (opcode)
      OP_RTYPE: begin
        wb_dec = 2'b10;
        ex_dec = 4'b1100;
      end
      OP_LW: begin
        wb_dec = 2'b11;
        m_dec  = 3'b010;
        ex_dec = 4'b0001;
      end
      OP_SW: begin
        m_dec  = 3'b001;
        ex_dec = 4'b0001;
      end
      OP_BEQ: begin
        m_dec  = 3'b100;
        ex_dec = 4'b0010;
      end
      default: begin
        wb_dec = 2'b00;
      end
    endcase
  end

  // Load-use hazard: the load now in EX targets a register the current
  // instruction reads. A load into $0 never creates a real dependency.
  assign ID_stall = ID_EX_m[1] && (ID_EX_instr_2016 != 5'd0) &&
                    ((ID_EX_instr_2016 == rs) || (ID_EX_instr_2016 == rt));

  // Stall and flush both just zero the control bundles; together they still
  // produce one bubble since there is only one ID/EX slot to clear.
  assign bubble = ID_stall || EX_MEM_PCSrc;

  // ID/EX pipeline register. Data fields always load; only control is
  // squashed on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_wb         <= '0;
      ID_EX_m          <= '0;
      ID_EX_ex         <= '0;
      ID_EX_npc        <= '0;
      ID_EX_readdat1   <= '0;
      ID_EX_readdat2   <= '0;
      ID_EX_sign_ext   <= '0;
      ID_EX_instr_2016 <= '0;
      ID_EX_instr_1511 <= '0;
    end else begin
      ID_EX_wb         <= bubble ? 2'b00   : wb_dec;
      ID_EX_m          <= bubble ? 3'b000  : m_dec;
      ID_EX_ex         <= bubble ? 4'b0000 : ex_dec;
      ID_EX_npc        <= IF_ID_npc;
      ID_EX_readdat1   <= rs_val;
      ID_EX_readdat2   <= rt_val;
      ID_EX_sign_ext   <= sign_ext;
      ID_EX_instr_2016 <= IF_ID_instr[20:16];
      ID_EX_instr_1511 <= IF_ID_instr[15:11];
    end
  end

endmodule

// File: tb/tb_idecode.sv
// ---------------------------------------------------------------------------
// tb_idecode -- directed self-checking bench for idecode.
//
// Drives hand-built instruction and writeback vectors and compares the ID/EX
// outputs and the stall flag against hand-computed values.
// ---------------------------------------------------------------------------
module tb_idecode;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        mem_wb_regwrite;
  logic [4:0]  mem_wb_writereg;
  logic [31:0] wb_writedata;
  logic        ex_mem_pcsrc;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_readdat1;
  logic [31:0] id_ex_readdat2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0]  id_ex_instr_2016;
  logic [4:0]  id_ex_instr_1511;
  logic        id_stall;

  int check_count;
  int error_count;

  idecode dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_ID_instr      (if_id_instr),
    .IF_ID_npc        (if_id_npc),
    .MEM_WB_RegWrite  (mem_wb_regwrite),
    .MEM_WB_writereg  (mem_wb_writereg),
    .WB_writedata     (wb_writedata),
    .EX_MEM_PCSrc     (ex_mem_pcsrc),
    .ID_EX_wb         (id_ex_wb),
    .ID_EX_m          (id_ex_m),
    .ID_EX_ex         (id_ex_ex),
    .ID_EX_npc        (id_ex_npc),
    .ID_EX_readdat1   (id_ex_readdat1),
    .ID_EX_readdat2   (id_ex_readdat2),
    .ID_EX_sign_ext   (id_ex_sign_ext),
    .ID_EX_instr_2016 (id_ex_instr_2016),
    .ID_EX_instr_1511 (id_ex_instr_1511),
    .ID_stall         (id_stall)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one set of inputs and lets the combinational paths settle.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] npc,
                               input logic regwrite, input logic [4:0] writereg,
                               input logic [31:0] wdata, input logic pcsrc);
    if_id_instr     = instr;
    if_id_npc       = npc;
    mem_wb_regwrite = regwrite;
    mem_wb_writereg = writereg;
    wb_writedata    = wdata;
    ex_mem_pcsrc    = pcsrc;
    #1;
  endtask

  // Advances one rising edge and samples 1 ns later, away from the edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Checks the three control bundles together.
  task automatic checkControl(input string tag, input logic [1:0] wb,
                              input logic [2:0] m, input logic [3:0] ex);
    checkOutput({tag, "_wb"}, {30'd0, id_ex_wb}, {30'd0, wb});
    checkOutput({tag, "_m"},  {29'd0, id_ex_m},  {29'd0, m});
    checkOutput({tag, "_ex"}, {28'd0, id_ex_ex}, {28'd0, ex});
  endtask

  // Directed sequence with hand-computed expected values.
  initial begin
    check_count = 0;
    error_count = 0;
    rst_n = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

    #1;
    $display("[TB] reset state");
    checkControl("rst", 2'b00, 3'b000, 4'b0000);
    checkOutput("rst_npc", id_ex_npc, 32'h0);
    checkOutput("rst_rd1", id_ex_readdat1, 32'h0);
    checkOutput("rst_sx", id_ex_sign_ext, 32'h0);
    checkOutput("rst_stall", {31'd0, id_stall}, 32'd0);
    stepClock();
    rst_n = 1'b1;

    $display("[TB] write $5 then add $6,$5,$6");
    applyStimulus(32'h0000_0000, 32'd1, 1'b1, 5'd5, 32'h0000_ABCD, 1'b0);
    stepClock();
    checkControl("nop", 2'b10, 3'b000, 4'b1100);
    applyStimulus(32'h00A6_3020, 32'd2, 1'b0, 5'd0, 32'h0, 1'b0);
    stepClock();
    checkOutput("add_rd1", id_ex_readdat1, 32'h0000_ABCD);
    checkOutput("add_rd2", id_ex_readdat2, 32'h0);
    checkControl("add", 2'b10, 3'b000, 4'b1100);
    checkOutput("add_rd", {27'd0, id_ex_instr_1511}, 32'd6);
    checkOutput("add_rt", {27'd0, id_ex_instr_2016}, 32'd6);
    checkOutput("add_sx", id_ex_sign_ext, 32'h0000_3020);
    checkOutput("add_npc", id_ex_npc, 32'd2);

    $display("[TB] write-through");
    applyStimulus(32'h00A6_3020, 32'd3, 1'b1, 5'd5, 32'h1234_5678, 1'b0);
    stepClock();
    checkOutput("wt_rd1", id_ex_readdat1, 32'h1234_5678);

    $display("[TB] writes to $0");
    applyStimulus(32'h0000_0020, 32'd4, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    stepClock();
    checkOutput("r0_same_cycle", id_ex_readdat1, 32'h0);
    applyStimulus(32'h0000_0020, 32'd5, 1'b0, 5'd0, 32'h0, 1'b0);
    stepClock();
    checkOutput("r0_rd1", id_ex_readdat1, 32'h0);
    checkOutput("r0_rd2", id_ex_readdat2, 32'h0);

    $display("[TB] load-use hazard on rs");
    applyStimulus(32'h8C22_FFFC, 32'd6, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("lw_nostall", {31'd0, id_stall}, 32'd0);
    stepClock();
    checkOutput("lw_sx", id_ex_sign_ext, 32'hFFFF_FFFC);
    checkControl("lw", 2'b11, 3'b010, 4'b0001);
    checkOutput("lw_rt", {27'd0, id_ex_instr_2016}, 32'd2);
    applyStimulus(32'h0044_1820, 32'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("lu_stall_rs", {31'd0, id_stall}, 32'd1);
    stepClock();
    checkControl("lu_bubble", 2'b00, 3'b000, 4'b0000);
    checkOutput("lu_rd", {27'd0, id_ex_instr_1511}, 32'd3);
    checkOutput("lu_npc", id_ex_npc, 32'd7);
    checkOutput("lu_stall_clear", {31'd0, id_stall}, 32'd0);

    $display("[TB] load-use on rt with simultaneous flush");
    applyStimulus(32'h8C22_FFFC, 32'd8, 1'b0, 5'd0, 32'h0, 1'b0);
    stepClock();
    applyStimulus(32'h0082_2020, 32'd9, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("lu_stall_rt", {31'd0, id_stall}, 32'd1);
    stepClock();
    checkControl("stall_flush", 2'b00, 3'b000, 4'b0000);

    $display("[TB] load into $0 does not stall");
    applyStimulus(32'h8C20_FFFC, 32'd10, 1'b0, 5'd0, 32'h0, 1'b0);
    stepClock();
    applyStimulus(32'h0000_2020, 32'd11, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("lw0_stall", {31'd0, id_stall}, 32'd0);
    stepClock();
    checkControl("lw0_next", 2'b10, 3'b000, 4'b1100);

    $display("[TB] flush on sw, writeback still lands");
    applyStimulus(32'hAC22_0008, 32'h40, 1'b1, 5'd7, 32'hCAFE_F00D, 1'b1);
    stepClock();
    checkControl("flush", 2'b00, 3'b000, 4'b0000);
    checkOutput("flush_npc", id_ex_npc, 32'h40);
    checkOutput("flush_sx", id_ex_sign_ext, 32'h8);
    applyStimulus(32'h00E0_0020, 32'h41, 1'b0, 5'd0, 32'h0, 1'b0);
    stepClock();
    checkOutput("flush_wb_r7", id_ex_readdat1, 32'hCAFE_F00D);

    $display("[TB] sw, addi, beq decode");
    applyStimulus(32'hAC22_0008, 32'h42, 1'b0, 5'd0, 32'h0, 1'b0);
    stepClock();
    checkControl("sw", 2'b00, 3'b001, 4'b0001);
    applyStimulus(32'h2022_0005, 32'h43, 1'b0, 5'd0, 32'h0, 1'b0);
    stepClock();
    checkControl("addi", 2'b00, 3'b000, 4'b0000);
    checkOutput("addi_sx", id_ex_sign_ext, 32'h5);
    applyStimulus(32'h1022_0003, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0);
    stepClock();
    checkControl("beq", 2'b00, 3'b100, 4'b0010);

    $display("[TB] asynchronous reset between edges");
    #2;
    rst_n = 1'b0;
    #1;
    checkControl("arst", 2'b00, 3'b000, 4'b0000);
    checkOutput("arst_npc", id_ex_npc, 32'h0);
    checkOutput("arst_sx", id_ex_sign_ext, 32'h0);
    checkOutput("arst_rt", {27'd0, id_ex_instr_2016}, 32'd0);
    checkOutput("arst_stall", {31'd0, id_stall}, 32'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(32'h00A6_3020, 32'h50, 1'b0, 5'd0, 32'h0, 1'b0);
    stepClock();
    checkOutput("post_rst_rd1", id_ex_readdat1, 32'h0);
    checkControl("post_rst", 2'b10, 3'b000, 4'b1100);
    checkOutput("post_rst_npc", id_ex_npc, 32'h50);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
